harvos_icache: RTL and testbench

Direct-mapped, read-only instruction cache between the core's instruction-fetch port and the SoC fetch path (boot-ROM/RAM-arbiter select). It serves fetch hits from internal flop arrays and refills whole lines on a miss using one outstanding word request at a time. It supports a single-cycle flush-all for self-modifying-code and loader sequences. Faults during refill go back to the core and are never cached.

---
 rtl/harvos_icache.sv | 182 ++++++++++++++++++
 tb/tb_harvos_icache.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/harvos_icache.sv
// ---------------------------------------------------------------------------
// harvos_icache : direct-mapped read-only instruction cache, whole-line refill
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module harvos_icache #(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  output logic        cpu_fault,
  input  logic        flush_all,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  input  logic        mem_fault
);

  localparam int c_wb = $clog2(LINE_WORDS);
  localparam int c_ob = c_wb + 2;
  localparam int c_ib = $clog2(LINES);
  localparam int c_tb = 32 - c_ob - c_ib;
  localparam logic [c_wb-1:0] c_last = c_wb'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [LINES-1:0] r_valid;
  logic [c_tb-1:0]  r_tags [LINES];
  logic [31:0]      r_data [LINES][LINE_WORDS];

  logic [c_ib-1:0]  r_idx;
  logic [c_wb-1:0]  r_off;
  logic [c_tb-1:0]  r_tag_lat;
  logic [c_wb-1:0]  r_cnt;
  logic             r_flush_pend;
  logic [31:0]      r_rdata;
  logic             r_fault;
  logic [31:0]      r_mem_addr;

  logic [c_tb-1:0]  w_tag;
  logic [c_ib-1:0]  w_idx;
  logic [c_wb-1:0]  w_off;
  logic             w_hit;
  logic             w_req_take;
  logic             w_word_ok;
  logic             w_word_bad;
  logic             w_last;
  logic             w_unused_addr;

  assign w_off         = cpu_addr[c_ob-1:2];
  assign w_idx         = cpu_addr[c_ob+c_ib-1:c_ob];
  assign w_tag         = cpu_addr[31:c_ob+c_ib];
  assign w_unused_addr = ^cpu_addr[1:0];

  assign w_hit      = r_valid[w_idx] && (r_tags[w_idx] == w_tag);
  assign w_req_take = (r_state == S_IDLE) && cpu_req && !flush_all;
  assign w_word_ok  = (r_state == S_REFILL) && mem_rvalid && !mem_fault;
  assign w_word_bad = (r_state == S_REFILL) && mem_rvalid && mem_fault;
  assign w_last     = (r_cnt == c_last);

  assign cpu_rdata = r_rdata;
  assign mem_addr  = r_mem_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cpu_rvalid  = 1'b0;
    cpu_fault   = 1'b0;
    mem_req     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_take) begin
          w_state_nxt = w_hit ? S_RESP : S_REFILL;
        end
      end
      S_REFILL: begin
        mem_req = 1'b1;
        if (w_word_bad || (w_word_ok && w_last)) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        cpu_rvalid  = 1'b1;
        cpu_fault   = r_fault;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid      <= '0;
      r_idx        <= '0;
      r_off        <= '0;
      r_tag_lat    <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      r_rdata      <= '0;
      r_fault      <= 1'b0;
      r_mem_addr   <= '0;
    end else begin
      if (w_req_take) begin
        r_fault <= 1'b0;
        if (w_hit) begin
          r_rdata <= r_data[w_idx][w_off];
        end else begin
          // Invalidate up front so a partial line can never be seen as valid.
          r_valid[w_idx] <= 1'b0;
          r_idx          <= w_idx;
          r_off          <= w_off;
          r_tag_lat      <= w_tag;
          r_cnt          <= '0;
          r_flush_pend   <= 1'b0;
          r_mem_addr     <= {w_tag, w_idx, {c_ob{1'b0}}};
        end
      end

      if (r_state == S_REFILL && flush_all) begin
        r_flush_pend <= 1'b1;
      end

      if (w_word_bad) begin
        r_rdata <= '0;
        r_fault <= 1'b1;
      end

      if (w_word_ok) begin
        if (r_cnt == r_off) begin
          r_rdata <= mem_rdata;
        end
        if (w_last) begin
          r_valid[r_idx] <= !(r_flush_pend || flush_all);
          r_flush_pend   <= 1'b0;
        end else begin
          r_cnt      <= r_cnt + c_wb'(1);
          r_mem_addr <= r_mem_addr + 32'd4;
        end
      end

      // A flush on any edge wins over the line validation above.
      if (flush_all) begin
        r_valid <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_word_ok) begin
      r_data[r_idx][r_cnt] <= mem_rdata;
      if (w_last) begin
        r_tags[r_idx] <= r_tag_lat;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_harvos_icache.sv
// ---------------------------------------------------------------------------
// tb_harvos_icache : directed + randomized check of harvos_icache (64x4 words)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_harvos_icache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        cpu_fault;
  logic        flush_all;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_fault;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] mem_tab [1024];
  bit          m_valid [64];
  logic [31:0] m_tag   [64];

  always #5 clk = ~clk;

  harvos_icache #(.LINES(64), .LINE_WORDS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_fault  (cpu_fault),
    .flush_all  (flush_all),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_fault  (mem_fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Backing memory: a random table inside the 4 KiB window, address-as-data above it.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a < 32'h1000) return mem_tab[a[11:2]];
    return {a[31:2], 2'b00};
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[a[9:4]] && (m_tag[a[9:4]] == (a >> 10));
  endfunction

  task automatic m_clear_all();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  // Drives one fetch and acts as the memory; stops at the response, at the
  // requested reset point, or when the cycle budget runs out.
  task automatic fetch(input logic [31:0] addr, input int max_stall, input int fault_at,
                       input int flush_at, input int rst_at,
                       output logic [31:0] data, output logic fault, output int lat,
                       output int words, output int addr_err, output bit seen);
    int stall;
    int rcyc;
    data = '0; fault = 1'b0; lat = 0; words = 0; addr_err = 0; seen = 1'b0; rcyc = 0;
    stall = $urandom_range(max_stall, 0);
    cpu_req  = 1'b1;
    cpu_addr = addr;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      mem_rvalid = 1'b0;
      mem_fault  = 1'b0;
      flush_all  = 1'b0;
      if (cpu_rvalid) begin
        seen    = 1'b1;
        data    = cpu_rdata;
        fault   = cpu_fault;
        cpu_req = 1'b0;
        break;
      end
      if (mem_req) begin
        if (mem_addr !== ((addr & ~32'hF) + (32'(words) << 2))) addr_err++;
        if (rcyc == flush_at) flush_all = 1'b1;
        rcyc++;
        if (rst_at >= 0 && words == rst_at) begin
          rst_n   = 1'b0;
          cpu_req = 1'b0;
          break;
        end
        if (stall > 0) begin
          stall--;
        end else begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_val(mem_addr);
          mem_fault  = (words == fault_at);
          words++;
          stall = $urandom_range(max_stall, 0);
        end
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic run(input logic [31:0] addr, input int max_stall, input int fault_at,
                     input int flush_at, input string tag);
    logic [31:0] d;
    logic        f;
    int          lat, words, aerr;
    bit          seen;
    bit          hit;
    bit          exp_fault;
    hit       = m_hit(addr);
    exp_fault = !hit && (fault_at >= 0);
    fetch(addr, max_stall, fault_at, flush_at, -1, d, f, lat, words, aerr, seen);
    check({tag, " rvalid"}, 32'(seen), 32'd1);
    check({tag, " rdata"}, d, exp_fault ? 32'd0 : mem_val(addr));
    check({tag, " fault"}, 32'(f), 32'(exp_fault));
    check({tag, " mem_req at resp"}, 32'(mem_req), 32'd0);
    check({tag, " words"}, 32'(words), hit ? 32'd0 : (exp_fault ? 32'(fault_at + 1) : 32'd4));
    check({tag, " addr seq errs"}, 32'(aerr), 32'd0);
    if (hit) check({tag, " hit latency"}, 32'(lat), 32'd1);
    else if (max_stall == 0 && !exp_fault) check({tag, " miss latency"}, 32'(lat), 32'd5);
    @(posedge clk);
    @(negedge clk);
    check({tag, " single pulse"}, 32'(cpu_rvalid), 32'd0);
    if (!hit) begin
      m_valid[addr[9:4]] = 1'b0;
      if (flush_at >= 0) m_clear_all();
      else if (!exp_fault) begin
        m_valid[addr[9:4]] = 1'b1;
        m_tag[addr[9:4]]   = addr >> 10;
      end
    end
  endtask

  task automatic flush_idle(input bit with_req, input logic [31:0] addr);
    flush_all = 1'b1;
    cpu_req   = with_req;
    cpu_addr  = addr;
    @(posedge clk);
    @(negedge clk);
    flush_all = 1'b0;
    cpu_req   = 1'b0;
    check("flush idle mem_req", 32'(mem_req), 32'd0);
    check("flush idle rvalid", 32'(cpu_rvalid), 32'd0);
    m_clear_all();
  endtask

  initial begin
    logic [31:0] d;
    logic        f;
    int          lat, words, aerr;
    bit          seen;
    logic [31:0] a;
    int          fa;

    rst_n = 1'b0; cpu_req = 1'b0; cpu_addr = '0; flush_all = 1'b0;
    mem_rdata = '0; mem_rvalid = 1'b0; mem_fault = 1'b0;
    for (int i = 0; i < 1024; i++) mem_tab[i] = 32'(i * 4);
    m_clear_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset rvalid", 32'(cpu_rvalid), 32'd0);
    check("reset fault", 32'(cpu_fault), 32'd0);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset rdata", cpu_rdata, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    rst_n = 1'b1;

    run(32'h0000_1008, 0, -1, -1, "cold miss");
    run(32'h0000_100C, 0, -1, -1, "refetch hit");

    flush_idle(1'b1, 32'h0000_1008);
    run(32'h0000_1000, 0, -1, -1, "post-flush 1000");
    run(32'h0000_2000, 0, -1, -1, "conflict 2000");
    run(32'h0000_1000, 0, -1, -1, "conflict 1000");

    run(32'h0000_3004, 0, 1, -1, "refill fault");
    run(32'h0000_3004, 0, -1, -1, "after fault");

    run(32'h0000_4008, 0, -1, 1, "flush in refill");
    run(32'h0000_4008, 0, -1, -1, "after refill flush");
    run(32'h0000_4008, 0, -1, -1, "refill flush rehit");

    fetch(32'h0000_5000, 0, -1, -1, 2, d, f, lat, words, aerr, seen);
    check("rst mid words", 32'(words), 32'd2);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_clear_all();
    check("rst mid mem_req", 32'(mem_req), 32'd0);
    check("rst mid rvalid", 32'(cpu_rvalid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst mid idle rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst mid idle mem_req", 32'(mem_req), 32'd0);
    run(32'h0000_5000, 0, -1, -1, "after rst refetch");

    for (int i = 0; i < 1024; i++) mem_tab[i] = $urandom;
    m_clear_all();
    flush_idle(1'b0, 32'h0);
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(49, 0) == 0) flush_idle($urandom_range(1, 0) == 1, $urandom_range(4095, 0));
      a  = 32'($urandom_range(4095, 0));
      fa = ($urandom_range(19, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
      run(a, 7, fa, -1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
